div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/div_arbiter.sv | 174 +++++++++++++++++
 tb/tb_div_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, watchdog limit and FSM encoding for div_arbiter
package div_pkg;
   localparam int DVEND_W_DEF = 16;
   localparam int DVSOR_W_DEF = 8;
   localparam int TMO_CYC_DEF = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } div_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, search starts at ptr
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant
);
   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int off = 0; off < NREQ; off++) begin
         idx = PW'((int'(ptr) + off) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - shares one divider among NREQ requesters, round-robin
// Optional RUN-state watchdog enabled by DIV_TIMEOUT_EN.
module div_arbiter
   import div_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DVEND_W = DVEND_W_DEF,
   parameter int DVSOR_W = DVSOR_W_DEF,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*DVEND_W-1:0]   dividend_in,
   input  logic [NREQ*DVSOR_W-1:0]   divisor_in,
   output logic [NREQ-1:0]           grant,
   output logic [NREQ-1:0]           done,
   output logic [DVSOR_W-1:0]        quotient,
   output logic [DVSOR_W-1:0]        remainder,
   output logic                      v,
   output logic                      err,
   output logic                      div_st,
   output logic [DVEND_W-1:0]        div_dividend,
   output logic [DVSOR_W-1:0]        div_divisor,
   input  logic                      div_ready,
   input  logic                      div_v,
   input  logic [DVSOR_W-1:0]        div_quotient,
   input  logic [DVSOR_W-1:0]        div_remainder
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   div_state_e          state_q, state_d;
   logic [NREQ-1:0]     grant_q, grant_d, done_q, done_d, arb_grant;
   logic                div_st_q, div_st_d, v_q, v_d, sticky_q, sticky_d;
   logic [DVEND_W-1:0]  dvd_q, dvd_d, win_dvd;
   logic [DVSOR_W-1:0]  dvs_q, dvs_d, win_dvs, quot_q, quot_d, rem_q, rem_d;
   logic [PW-1:0]       ptr_q, ptr_d, win_idx;

`ifdef DIV_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic          err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d;
   assign err = err_q;
`else
   assign err = (TMO_CYC < 0);
`endif

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
      .req   (req),
      .ptr   (ptr_q),
      .grant (arb_grant)
   );

   always_comb begin
      win_idx = '0;
      win_dvd = '0;
      win_dvs = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) begin
            win_idx = PW'(i);
            win_dvd = dividend_in[i*DVEND_W +: DVEND_W];
            win_dvs = divisor_in[i*DVSOR_W +: DVSOR_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      done_d   = '0;
      div_st_d = 1'b0;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      v_d      = v_q;
      sticky_d = sticky_q;
      ptr_d    = ptr_q;
`ifdef DIV_TIMEOUT_EN
      err_d    = err_q;
      tmo_d    = tmo_q;
`endif
      unique case (state_q)
         IDLE: begin
            // A launch is only legal once the divider reports ready.
            if (|req && div_ready) begin
               grant_d  = arb_grant;
               dvd_d    = win_dvd;
               dvs_d    = win_dvs;
               ptr_d    = PW'((int'(win_idx) + 1) % NREQ);
               div_st_d = 1'b1;
               state_d  = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = RUN;
`ifdef DIV_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         RUN: begin
            sticky_d = sticky_q | div_v;
            if (div_ready) begin
               quot_d  = div_quotient;
               rem_d   = div_remainder;
               v_d     = sticky_q | div_v;
               done_d  = grant_q;
               state_d = DONE;
            end
`ifdef DIV_TIMEOUT_EN
            else if (tmo_q == TW'(TMO_CYC - 1)) begin
               v_d     = 1'b1;
               err_d   = 1'b1;
               done_d  = grant_q;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         DONE: begin
            grant_d  = '0;
            sticky_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         done_q   <= '0;
         div_st_q <= 1'b0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         v_q      <= 1'b0;
         sticky_q <= 1'b0;
         ptr_q    <= '0;
`ifdef DIV_TIMEOUT_EN
         err_q    <= 1'b0;
         tmo_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         div_st_q <= div_st_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         v_q      <= v_d;
         sticky_q <= sticky_d;
         ptr_q    <= ptr_d;
`ifdef DIV_TIMEOUT_EN
         err_q    <= err_d;
         tmo_q    <= tmo_d;
`endif
      end
   end

   assign grant        = grant_q;
   assign done         = done_q;
   assign div_st       = div_st_q;
   assign div_dividend = dvd_q;
   assign div_divisor  = dvs_q;
   assign quotient     = quot_q;
   assign remainder    = rem_q;
   assign v            = v_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed bench with divider model and result scoreboard
module tb_div_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int SW   = 8;
   localparam int TMO  = 31;
   localparam int LAT  = 5;

   typedef struct packed {
      logic [NREQ-1:0] done;
      logic [SW-1:0]   q;
      logic [SW-1:0]   r;
      logic            v;
      logic            chk_qr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*DW-1:0] dividend_in = '0;
   logic [NREQ*SW-1:0] divisor_in = '0;
   logic [NREQ-1:0]    grant, done;
   logic [SW-1:0]      quotient, remainder;
   logic               v, err, div_st;
   logic [DW-1:0]      div_dividend;
   logic [SW-1:0]      div_divisor;
   logic               div_ready = 1'b1;
   logic               div_v = 1'b0;
   logic [SW-1:0]      div_quotient = '0;
   logic [SW-1:0]      div_remainder = '0;

   logic               busy = 1'b0;
   logic               stall = 1'b0;
   int                 cnt = 0;
   logic [DW-1:0]      m_dvd = '0;
   logic [SW-1:0]      m_dvs = 8'd1;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   logic [NREQ-1:0] got;

   always #5 clk = ~clk;

   div_arbiter #(.NREQ(NREQ), .DVEND_W(DW), .DVSOR_W(SW), .TMO_CYC(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .dividend_in   (dividend_in),
      .divisor_in    (divisor_in),
      .grant         (grant),
      .done          (done),
      .quotient      (quotient),
      .remainder     (remainder),
      .v             (v),
      .err           (err),
      .div_st        (div_st),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_ready     (div_ready),
      .div_v         (div_v),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder)
   );

   // Divider model: no reset, LAT cycles per op, overflow shown as an early one-cycle V pulse.
   always @(posedge clk) begin
      if (div_st) begin
         busy      <= 1'b1;
         cnt       <= LAT;
         m_dvd     <= div_dividend;
         m_dvs     <= div_divisor;
         div_ready <= 1'b0;
         div_v     <= 1'b0;
      end else if (busy && !stall) begin
         if (cnt == 1) begin
            busy          <= 1'b0;
            div_ready     <= 1'b1;
            div_v         <= 1'b0;
            div_quotient  <= SW'(m_dvd / DW'(m_dvs));
            div_remainder <= SW'(m_dvd % DW'(m_dvs));
         end else begin
            cnt   <= cnt - 1;
            div_v <= (cnt == LAT) && ((m_dvd / DW'(m_dvs)) > DW'(255));
         end
      end
   end

   function automatic exp_t predict(int idx, logic [DW-1:0] dvd, logic [SW-1:0] dvs);
      exp_t          e;
      logic [DW-1:0] full;
      full     = dvd / DW'(dvs);
      e.done   = NREQ'(1) << idx;
      e.q      = full[SW-1:0];
      e.r      = SW'(dvd % DW'(dvs));
      e.v      = (full >> SW) != '0;
      e.chk_qr = 1'b1;
      return e;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_job(int idx, logic [DW-1:0] dvd, logic [SW-1:0] dvs, bit push);
      dividend_in[idx*DW +: DW] = dvd;
      divisor_in[idx*SW +: SW]  = dvs;
      if (push) sb.push_back(predict(idx, dvd, dvs));
   endtask

   task automatic wait_done(int bound, output logic [NREQ-1:0] seen);
      exp_t e;
      seen = '0;
      for (int c = 0; c < bound && seen == '0; c++) begin
         @(negedge clk);
         check("grant_onehot0", 32'($onehot0(grant)), 1);
         if (done != '0) seen = done;
      end
      check("done_seen", 32'(seen != '0), 1);
      if (seen != '0) begin
         check("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("done_owner", seen, e.done);
            check("done_eq_grant", seen, grant);
            if (e.chk_qr) begin
               check("quotient", quotient, e.q);
               check("remainder", remainder, e.r);
            end
            check("v", v, e.v);
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_done", done, 0);
      check("rst_div_st", div_st, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_v", v, 0);
      check("rst_err", err, 0);
      rst = 1'b0;

      // Single job, request dropped right after grant.
      set_job(0, 16'd1000, 8'd7, 1'b1);
      req = 4'b0001;
      @(negedge clk);
      check("launch_grant", grant, 4'b0001);
      check("launch_st", div_st, 1);
      check("launch_dividend", div_dividend, 16'd1000);
      check("launch_divisor", div_divisor, 8'd7);
      req = '0;
      @(negedge clk);
      check("st_one_cycle", div_st, 0);
      wait_done(40, got);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("grant_clear", grant, 0);

      // Overflow on requester 1, then a clean job on requester 2.
      set_job(1, 16'h1234, 8'h10, 1'b1);
      req = 4'b0010;
      wait_done(40, got);
      req = '0;
      repeat (3) @(negedge clk);
      check("hold_quotient", quotient, 8'h23);
      check("hold_v", v, 1);
      set_job(2, 16'd500, 8'd9, 1'b1);
      req = 4'b0100;
      wait_done(40, got);
      req = '0;

      // Fairness from a fresh pointer.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_job(i, DW'(100 * (i + 1)), SW'(3 + 2 * i), 1'b1);
      sb.push_back(predict(0, 16'd100, 8'd3));
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_done(40, got);
         if (n == 4) req = '0;
      end
      repeat (2) @(negedge clk);
      check("idle_no_grant", grant, 0);
      check("sb_drained", sb.size(), 0);

      // Reset while the divider is busy.
      set_job(0, 16'd999, 8'd10, 1'b1);
      req = 4'b0001;
      for (int c = 0; c < 10 && !div_st; c++) @(negedge clk);
      check("rr_launch_seen", div_st, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_grant", grant, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_quotient", quotient, 0);
      check("mid_rst_remainder", remainder, 0);
      check("mid_rst_v", v, 0);
      check("mid_rst_busy", div_ready, 0);
      for (int c = 0; c < 20 && !div_ready; c++) begin
         @(negedge clk);
         check("no_st_while_busy", div_st, 0);
         check("no_done_after_rst", done, 0);
      end
      check("ready_back", div_ready, 1);
      wait_done(40, got);
      req = '0;

`ifdef DIV_TIMEOUT_EN
      begin
         exp_t e;
         e        = '0;
         e.done   = 4'b0010;
         e.v      = 1'b1;
         e.chk_qr = 1'b0;
         sb.push_back(e);
         stall = 1'b1;
         set_job(1, 16'd100, 8'd4, 1'b0);
         req = 4'b0010;
         wait_done(TMO + 20, got);
         req = '0;
         check("tmo_err", err, 1);
         @(negedge clk);
         check("tmo_done_pulse", done, 0);
         stall = 1'b0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench timeout");
   end
endmodule
